// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux select-line sequencer.
// Channel count, select width, FSM states and frame type.
package mux_scan_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } scan_state_t;

  typedef logic [NUM_CH-1:0] frame_t;
endpackage

// File: rtl/dwell_counter.sv
// Settle-time counter: counts enabled cycles on one channel.
// Ports: clk, rst_n, i_clear, i_enable in; o_done when count == DWELL_CYCLES-1.
module dwell_counter #(
  parameter int DWELL_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_done
);
  localparam int CW = $clog2(DWELL_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DWELL_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Clear wins over enable; the count parks at LAST rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_done = (r_cnt == LAST);
endmodule

// File: rtl/mux_scan_ctrl.sv
// Drives a 4:1 mux select, samples its output per channel, and
// hands the packed 4-bit frame downstream over valid/ready.
// Ports: clk, rst_n, start, mode_single, ch_sel, y_in, frame_ready in;
// s_out, frame_data, frame_valid, busy out.
// MUX_SCAN_PARITY_EN adds frame_parity (XOR of frame_data).
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode_single,
  input  logic [SEL_W-1:0] ch_sel,
  output logic [SEL_W-1:0] s_out,
  input  logic             y_in,
  output frame_t           frame_data,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             busy
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic             frame_parity
`endif
);
  scan_state_t      r_state;
  scan_state_t      w_state_nxt;
  logic [SEL_W-1:0] r_s;
  logic [SEL_W-1:0] r_ch;
  logic             r_mode;
  frame_t           r_frame;
  frame_t           w_frame_smp;
  logic             r_valid;
  logic             w_clr;
  logic             w_en;
  logic             w_done;
  logic             w_last;

  dwell_counter #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_clr),
    .i_enable(w_en),
    .o_done  (w_done)
  );

  // Last channel: the latched one in single mode, else channel 3.
  assign w_last = r_mode ? (r_s == r_ch)
                         : (r_s == SEL_W'(NUM_CH - 1));

  always_comb begin
    w_frame_smp       = r_frame;
    w_frame_smp[r_s]  = y_in;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_en        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = SETTLE;
          w_clr       = 1'b1;
        end
      end
      SETTLE: begin
        w_en = 1'b1;
        if (w_done) begin
          if (w_last) w_state_nxt = HOLD;
          else        w_clr       = 1'b1;
        end
      end
      HOLD: begin
        if (frame_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s     <= '0;
      r_ch    <= '0;
      r_mode  <= 1'b0;
      r_frame <= '0;
      r_valid <= 1'b0;
    end else if (r_state == IDLE) begin
      if (start) begin
        r_mode  <= mode_single;
        r_ch    <= ch_sel;
        r_frame <= '0;
        r_s     <= mode_single ? ch_sel : '0;
      end
    end else if (r_state == SETTLE) begin
      if (w_done) begin
        r_frame <= w_frame_smp;
        if (w_last) r_valid <= 1'b1;
        else        r_s     <= r_s + SEL_W'(1);
      end
    end else if (r_state == HOLD) begin
      if (frame_ready) r_valid <= 1'b0;
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  logic r_par;

  // Computed from the completed frame as HOLD is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else if ((r_state == IDLE) && start) begin
      r_par <= 1'b0;
    end else if ((r_state == SETTLE) && w_done && w_last) begin
      r_par <= ^w_frame_smp;
    end
  end

  assign frame_parity = r_par;
`endif

  assign s_out       = r_s;
  assign frame_data  = r_frame;
  assign frame_valid = r_valid;
  assign busy        = (r_state == SETTLE) || (r_state == HOLD);
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with DWELL_CYCLES = 4.
// A behavioural 4:1 mux closes the loop from s_out to y_in.
module tb_mux_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       mode_single;
  logic [1:0] ch_sel;
  logic [1:0] s_out;
  logic       y_in;
  logic [3:0] frame_data;
  logic       frame_valid;
  logic       frame_ready;
  logic       busy;
`ifdef MUX_SCAN_PARITY_EN
  logic       frame_parity;
`endif
  logic       a, b, c, d;
  int         n_chk = 0;
  int         n_fail = 0;
  logic       bad;

  always #5 clk = ~clk;

  // Combinational 4:1 mux model: s=0 -> a, 1 -> b, 2 -> c, 3 -> d.
  always_comb begin
    case (s_out)
      2'd0:    y_in = a;
      2'd1:    y_in = b;
      2'd2:    y_in = c;
      default: y_in = d;
    endcase
  end

  mux_scan_ctrl #(
    .DWELL_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode_single(mode_single),
    .ch_sel     (ch_sel),
    .s_out      (s_out),
    .y_in       (y_in),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .busy       (busy)
`ifdef MUX_SCAN_PARITY_EN
    ,
    .frame_parity(frame_parity)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode_single = 1'b0; ch_sel = 2'd0;
    frame_ready = 1'b0; a = 0; b = 0; c = 0; d = 0;
    tick(2);
    chk("rst_s_out", 32'(s_out), 32'd0);
    chk("rst_data", 32'(frame_data), 32'd0);
    chk("rst_valid", 32'(frame_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Full scan, a=1 b=0 c=1 d=0 -> 0101.
    a = 1; b = 0; c = 1; d = 0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_s0", 32'(s_out), 32'd0);
    tick(4);
    chk("t1_s1", 32'(s_out), 32'd1);
    tick(4);
    chk("t1_s2", 32'(s_out), 32'd2);
    tick(4);
    chk("t1_s3", 32'(s_out), 32'd3);
    tick(3);
    chk("t1_valid_early", 32'(frame_valid), 32'd0);
    tick(1);
    chk("t1_valid", 32'(frame_valid), 32'd1);
    chk("t1_data", 32'(frame_data), 32'h5);
`ifdef MUX_SCAN_PARITY_EN
    chk("t1_parity", 32'(frame_parity), 32'd0);
`endif
    frame_ready = 1'b1;
    tick(1);
    frame_ready = 1'b0;
    chk("t1_valid_drop", 32'(frame_valid), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // Single mode on channel 2; inputs wiggled after start.
    a = 0; b = 0; c = 1; d = 0;
    mode_single = 1'b1; ch_sel = 2'd2; start = 1'b1;
    tick(1);
    start = 1'b0; mode_single = 1'b0; ch_sel = 2'd0;
    bad = (s_out != 2'd2);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (s_out != 2'd2) bad = 1'b1;
    end
    chk("t2_valid_early", 32'(frame_valid), 32'd0);
    tick(1);
    chk("t2_valid", 32'(frame_valid), 32'd1);
    chk("t2_data", 32'(frame_data), 32'h4);
    chk("t2_s_only2", 32'(bad), 32'd0);
    frame_ready = 1'b1;
    tick(1);
    frame_ready = 1'b0;
    chk("t2_valid_drop", 32'(frame_valid), 32'd0);

    // Backpressure on a 1111 frame.
    a = 1; b = 1; c = 1; d = 1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(16);
    chk("t3_valid", 32'(frame_valid), 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (!frame_valid || frame_data != 4'hF || s_out != 2'd3) bad = 1'b1;
    end
    chk("t3_hold_stable", 32'(bad), 32'd0);
    frame_ready = 1'b1;
    tick(1);
    frame_ready = 1'b0;
    chk("t3_valid_drop", 32'(frame_valid), 32'd0);
    chk("t3_idle", 32'(busy), 32'd0);

    // Re-pulsed start mid-scan and in HOLD; frame 0111.
    a = 1; b = 1; c = 1; d = 0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    start = 1'b1; mode_single = 1'b1; ch_sel = 2'd0;
    tick(1);
    start = 1'b0; mode_single = 1'b0;
    chk("t4_s_mid", 32'(s_out), 32'd1);
    tick(11);
    chk("t4_valid", 32'(frame_valid), 32'd1);
    chk("t4_data", 32'(frame_data), 32'h7);
`ifdef MUX_SCAN_PARITY_EN
    chk("t4_parity", 32'(frame_parity), 32'd1);
`endif
    start = 1'b1; frame_ready = 1'b1;
    tick(1);
    start = 1'b0; frame_ready = 1'b0;
    chk("t4_valid_drop", 32'(frame_valid), 32'd0);
    chk("t4_idle", 32'(busy), 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (busy || frame_valid) bad = 1'b1;
    end
    chk("t4_one_frame", 32'(bad), 32'd0);

    // Asynchronous reset mid-scan; frame 1001 afterwards.
    a = 1; b = 0; c = 0; d = 1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(8);
    chk("t5_partial", 32'(frame_data), 32'h1);
    chk("t5_s_pre", 32'(s_out), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_s", 32'(s_out), 32'd0);
    chk("t5_rst_data", 32'(frame_data), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    tick(3);
    chk("t5_rst_valid", 32'(frame_valid), 32'd0);
    rst_n = 1'b1;
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(15);
    chk("t5_valid_early", 32'(frame_valid), 32'd0);
    tick(1);
    chk("t5_valid", 32'(frame_valid), 32'd1);
    chk("t5_data", 32'(frame_data), 32'h9);
    frame_ready = 1'b1;
    tick(1);
    frame_ready = 1'b0;
    chk("t5_valid_drop", 32'(frame_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Select-line sequencer that sits directly upstream of the 4:1 mux (Mux4x1). It drives the mux select `s` and reads the mux output `y` back. On `start` it steps through the four channels, or through one chosen channel. On each channel it waits a programmable settle time, then samples `y`. The samples are packed into a 4-bit frame, which is handed downstream over a valid/ready handshake.

Parameters:
- DWELL_CYCLES, 4: cycles `s_out` is held on each channel; `y_in` is sampled on the last of them. Legal range is >= 1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  scan request; sampled only in IDLE.
- mode_single  input  1  0 = scan channels 0..3; 1 = scan only `ch_sel`. Sampled together with `start`.
- ch_sel  input  2  channel for single mode. Sampled together with `start`.
- s_out  output  2  mux select; connects to mux `s`.
- y_in  input  1  mux output `y`.
- frame_data  output  4  bit i = sample taken from channel i.
- frame_valid  output  1  frame available.
- frame_ready  input  1  downstream accepts the frame.
- busy  output  1  high in SETTLE and HOLD.

Behaviour:
- Reset (async assert, sync release): state = IDLE, s_out = 0, frame_data = 0, frame_valid = 0, busy = 0, dwell counter = 0, latched mode = 0.
- The FSM has three states: IDLE, SETTLE, HOLD.
- IDLE, start = 1:
  - latch mode_single and ch_sel;
  - clear frame_data to 0 and the dwell counter to 0;
  - s_out <= 0 in scan mode, or ch_sel in single mode;
  - next state SETTLE.
  - With start = 0, stay in IDLE; s_out keeps its last value.
- SETTLE:
  - Each cycle the counter increments.
  - When counter == DWELL_CYCLES-1, at that edge frame_data[s_out] <= y_in.
  - If the current channel is the last one (3 in scan mode, the latched ch_sel in single mode), next state is HOLD.
  - Otherwise s_out <= s_out+1 and the counter <= 0.
- HOLD:
  - frame_valid = 1 (registered, asserted on entry).
  - frame_data and s_out are held stable.
  - frame_valid && frame_ready completes the transfer: frame_valid <= 0, next state IDLE.
- Latency:
  - `start` accepted at edge t gives frame_valid high after edge t + 4*DWELL_CYCLES in scan mode.
  - In single mode, frame_valid is high after edge t + DWELL_CYCLES.
- Boundary conditions:
  - start is ignored in SETTLE and HOLD; it is never queued.
  - start and frame_ready both high in HOLD: the transfer completes and the start is ignored. A new start must arrive in IDLE.
  - frame_ready while not valid has no effect.
  - Changes on mode_single or ch_sel during a scan have no effect (latched values are used).
  - The counter is $clog2(DWELL_CYCLES+1) bits wide and saturates to no wrap; s_out never wraps past 3 within one scan.
  - Reset mid-scan: immediate return to reset values; any partial frame is discarded and no valid is produced.
  - DWELL_CYCLES = 1: y_in is sampled on the same cycle s_out takes the channel value, so an external mux must be combinational.

Optional Feature:
- Macro MUX_SCAN_PARITY_EN.
- Defined: adds output frame_parity (1 bit) = XOR of frame_data. It is registered, valid and stable whenever frame_valid = 1, and reset to 0.
- Undefined: the port and logic are absent; everything else is identical.

Decomposition:
- Package mux_scan_pkg:
  - NUM_CH = 4, SEL_W = 2;
  - typedef enum logic [1:0] {IDLE, SETTLE, HOLD} scan_state_t;
  - typedef logic [NUM_CH-1:0] frame_t.
- One natural sub-module, dwell_counter:
  - parameterised by DWELL_CYCLES;
  - inputs clear and enable; output `done` when count == DWELL_CYCLES-1.
- The FSM and frame register stay in the top-level module.

Test Plan (DWELL_CYCLES = 4; the bench instantiates Mux4x1 between s_out and y_in):
- Scan, a=1 b=0 c=1 d=0, start pulse → s_out steps 0,1,2,3 every 4 cycles; frame_valid rises 16 cycles after the start edge; frame_data = 4'b0101; with ready=1 it drops the next cycle.
- Single mode ch_sel=2, c=1, others 0 → s_out = 2 for 4 cycles; frame_data = 4'b0100, valid after 4 cycles; the other channels are never selected.
- Backpressure: full scan with a=b=c=d=1 and frame_ready low for 10 cycles → frame_valid stays high and frame_data = 4'b1111 stable with s_out = 3; the transfer completes on the first ready-high cycle.
- start re-pulsed at cycle 5 of a scan, and again in HOLD together with ready → both ignored; exactly one frame is produced and the FSM returns to IDLE.
- rst_n low at cycle 9 of a scan → all outputs go to 0 immediately (async); no frame_valid; a new start after release gives a correct full frame.
- With MUX_SCAN_PARITY_EN, frame 4'b0111 → frame_parity = 1; frame 4'b0101 → frame_parity = 0.
